// File: rtl/pe_pkg.sv
// pe_pkg: shared types and elaboration-time helpers for the pe_acc
// multiply-accumulate processing element.
//   pe_state_e : window FSM states (IDLE, ACCUM)
//   clog2      : ceiling log2, clog2(1) = 0
//   acc_width  : accumulator width that cannot overflow over a full window
package pe_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } pe_state_e;

  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  // Product width plus growth for the lane adder tree and the window sum.
  function automatic int acc_width(input int data_width, input int weight_width,
                                   input int lanes, input int acc_depth);
    return data_width + weight_width + clog2(lanes) + clog2(acc_depth);
  endfunction

endpackage

// File: rtl/pe_lane_mul.sv
// pe_lane_mul: one registered lane multiplier.
//   clk, rst : clock, synchronous active-high reset
//   en       : capture a new product this cycle
//   pixel    : DATA_WIDTH pixel
//   weight   : WEIGHT_WIDTH weight
//   product  : registered DATA_WIDTH+WEIGHT_WIDTH product, signed when SIGNED=1
module pe_lane_mul #(
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter bit SIGNED       = 1'b0,
  localparam int PROD_WIDTH  = DATA_WIDTH + WEIGHT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [DATA_WIDTH-1:0]   pixel,
  input  logic [WEIGHT_WIDTH-1:0] weight,
  output logic [PROD_WIDTH-1:0]   product
);

  logic [PROD_WIDTH-1:0] pixel_ext;
  logic [PROD_WIDTH-1:0] weight_ext;
  logic [PROD_WIDTH-1:0] product_next;

  // Extending both operands to the full product width first means a plain
  // modular multiply yields the exact result in either signedness.
  generate
    if (SIGNED) begin : g_signed
      assign pixel_ext  = PROD_WIDTH'($signed(pixel));
      assign weight_ext = PROD_WIDTH'($signed(weight));
    end else begin : g_unsigned
      assign pixel_ext  = PROD_WIDTH'(pixel);
      assign weight_ext = PROD_WIDTH'(weight);
    end
  endgenerate

  assign product_next = pixel_ext * weight_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      product <= '0;
    end else if (en) begin
      product <= product_next;
    end
  end

endmodule

// File: rtl/pe_acc.sv
// pe_acc: multi-lane multiply-accumulate processing element.
//   clk, rst        : clock, synchronous active-high reset
//   w_load, w_in    : load the per-lane weight register (lane 0 in LSBs)
//   pe_valid        : pe_input holds a valid tap
//   pe_input        : per-lane pixels (lane 0 in LSBs)
//   pe_clear        : abort the current window
//   pe_pixel_out    : pe_input delayed one cycle
//   pe_valid_out    : pe_valid delayed one cycle
//   pe_weight_out   : current weight register
//   pe_output       : last completed window sum
//   pe_output_valid : one-cycle pulse when pe_output updates
//   pe_busy         : a window is in progress
module pe_acc
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int LANES        = 4,
  parameter int ACC_DEPTH    = 9,
  parameter bit SIGNED       = 1'b0,
  localparam int ACC_WIDTH   = acc_width(DATA_WIDTH, WEIGHT_WIDTH, LANES, ACC_DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          w_load,
  input  logic [LANES*WEIGHT_WIDTH-1:0] w_in,
  input  logic                          pe_valid,
  input  logic [LANES*DATA_WIDTH-1:0]   pe_input,
  input  logic                          pe_clear,
  output logic [LANES*DATA_WIDTH-1:0]   pe_pixel_out,
  output logic                          pe_valid_out,
  output logic [LANES*WEIGHT_WIDTH-1:0] pe_weight_out,
  output logic [ACC_WIDTH-1:0]          pe_output,
  output logic                          pe_output_valid,
  output logic                          pe_busy
);

  localparam int PROD_WIDTH = DATA_WIDTH + WEIGHT_WIDTH;
  localparam int TAP_WIDTH  = (clog2(ACC_DEPTH) > 0) ? clog2(ACC_DEPTH) : 1;
  localparam logic [TAP_WIDTH-1:0] LAST_TAP = TAP_WIDTH'(ACC_DEPTH - 1);

  logic [LANES*WEIGHT_WIDTH-1:0] w_reg;
  logic [LANES*DATA_WIDTH-1:0]   pixel_reg;
  logic                          valid_reg;

  pe_state_e             state_reg, state_next;
  logic [TAP_WIDTH-1:0]  tap_cnt_reg, tap_cnt_next;
  logic                  tag_first, tag_last;

  logic                  s1_valid_reg, s1_first_reg, s1_last_reg;
  logic                  tap_accept;
  logic [LANES-1:0][PROD_WIDTH-1:0] prod;
  logic [LANES-1:0][ACC_WIDTH-1:0]  prod_ext;
  logic [ACC_WIDTH-1:0]  lane_sum;
  logic [ACC_WIDTH-1:0]  acc_reg, acc_next;
  logic [ACC_WIDTH-1:0]  out_reg;
  logic                  out_valid_reg;

  // Clear wins over a simultaneous tap.
  assign tap_accept = pe_valid && !pe_clear;

  // Stage 1: per-lane products using the weights held before any same-cycle load.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      pe_lane_mul #(
        .DATA_WIDTH  (DATA_WIDTH),
        .WEIGHT_WIDTH(WEIGHT_WIDTH),
        .SIGNED      (SIGNED)
      ) u_mul (
        .clk    (clk),
        .rst    (rst),
        .en     (tap_accept),
        .pixel  (pe_input[gi*DATA_WIDTH +: DATA_WIDTH]),
        .weight (w_reg[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH]),
        .product(prod[gi])
      );

      if (SIGNED) begin : g_sext
        assign prod_ext[gi] = ACC_WIDTH'($signed(prod[gi]));
      end else begin : g_zext
        assign prod_ext[gi] = ACC_WIDTH'(prod[gi]);
      end
    end
  endgenerate

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_sum = lane_sum + prod_ext[i];
    end
  end

  // A first tag reloads instead of adding, so back-to-back windows need no bubble.
  assign acc_next = s1_first_reg ? lane_sum : (acc_reg + lane_sum);

  // Window FSM: tags each accepted tap as first and/or last of its window.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      tap_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      tap_cnt_reg <= tap_cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    tap_cnt_next = tap_cnt_reg;
    tag_first    = 1'b0;
    tag_last     = 1'b0;
    if (pe_clear) begin
      state_next   = IDLE;
      tap_cnt_next = '0;
    end else if (pe_valid) begin
      case (state_reg)
        IDLE: begin
          tag_first = 1'b1;
          if (ACC_DEPTH == 1) begin
            tag_last = 1'b1;
          end else begin
            state_next   = ACCUM;
            tap_cnt_next = TAP_WIDTH'(1);
          end
        end
        ACCUM: begin
          if (tap_cnt_reg == LAST_TAP) begin
            tag_last     = 1'b1;
            state_next   = IDLE;
            tap_cnt_next = '0;
          end else begin
            tap_cnt_next = tap_cnt_reg + TAP_WIDTH'(1);
          end
        end
        default: begin
          state_next   = IDLE;
          tap_cnt_next = '0;
        end
      endcase
    end
  end

  // Forwarding, weight register, stage-1 tags and stage-2 accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_reg         <= '0;
      pixel_reg     <= '0;
      valid_reg     <= 1'b0;
      s1_valid_reg  <= 1'b0;
      s1_first_reg  <= 1'b0;
      s1_last_reg   <= 1'b0;
      acc_reg       <= '0;
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      pixel_reg     <= pe_input;
      valid_reg     <= pe_valid;
      if (w_load) begin
        w_reg <= w_in;
      end
      s1_valid_reg  <= tap_accept;
      s1_first_reg  <= tag_first;
      s1_last_reg   <= tag_last;
      out_valid_reg <= 1'b0;
      // A clear also kills the tap currently leaving stage 1.
      if (s1_valid_reg && !pe_clear) begin
        acc_reg <= acc_next;
        if (s1_last_reg) begin
          out_reg       <= acc_next;
          out_valid_reg <= 1'b1;
        end
      end
    end
  end

  assign pe_pixel_out    = pixel_reg;
  assign pe_valid_out    = valid_reg;
  assign pe_weight_out   = w_reg;
  assign pe_output       = out_reg;
  assign pe_output_valid = out_valid_reg;
  assign pe_busy         = (state_reg == ACCUM);

endmodule

// File: tb/tb_pe_acc.sv
// tb_pe_acc: scoreboard bench for pe_acc. Three instances: unsigned depth 9
// (id 0), signed depth 9 (id 1) and unsigned depth 1 (id 2). Stimulus pushes
// the hand-computed window result and its due cycle; a monitor pops on pulses.
module tb_pe_acc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        wld  [3];
  logic [31:0] win  [3];
  logic        vld  [3];
  logic [31:0] pix  [3];
  logic        clr  [3];
  logic [31:0] pix_o[3];
  logic        vo   [3];
  logic [31:0] wo   [3];
  logic        ov   [3];
  logic        busy [3];
  logic [21:0] a_out, s_out;
  logic [17:0] d_out;
  logic [31:0] outv [3];

  assign outv[0] = 32'(a_out);
  assign outv[1] = 32'(s_out);
  assign outv[2] = 32'(d_out);

  pe_acc #(.DATA_WIDTH(8), .WEIGHT_WIDTH(8), .LANES(4), .ACC_DEPTH(9), .SIGNED(1'b0)) u_a (
    .clk(clk), .rst(rst), .w_load(wld[0]), .w_in(win[0]), .pe_valid(vld[0]),
    .pe_input(pix[0]), .pe_clear(clr[0]), .pe_pixel_out(pix_o[0]), .pe_valid_out(vo[0]),
    .pe_weight_out(wo[0]), .pe_output(a_out), .pe_output_valid(ov[0]), .pe_busy(busy[0]));

  pe_acc #(.DATA_WIDTH(8), .WEIGHT_WIDTH(8), .LANES(4), .ACC_DEPTH(9), .SIGNED(1'b1)) u_s (
    .clk(clk), .rst(rst), .w_load(wld[1]), .w_in(win[1]), .pe_valid(vld[1]),
    .pe_input(pix[1]), .pe_clear(clr[1]), .pe_pixel_out(pix_o[1]), .pe_valid_out(vo[1]),
    .pe_weight_out(wo[1]), .pe_output(s_out), .pe_output_valid(ov[1]), .pe_busy(busy[1]));

  pe_acc #(.DATA_WIDTH(8), .WEIGHT_WIDTH(8), .LANES(4), .ACC_DEPTH(1), .SIGNED(1'b0)) u_d (
    .clk(clk), .rst(rst), .w_load(wld[2]), .w_in(win[2]), .pe_valid(vld[2]),
    .pe_input(pix[2]), .pe_clear(clr[2]), .pe_pixel_out(pix_o[2]), .pe_valid_out(vo[2]),
    .pe_weight_out(wo[2]), .pe_output(d_out), .pe_output_valid(ov[2]), .pe_busy(busy[2]));

  typedef struct {
    int          id;
    logic [31:0] val;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tap(input int id, input logic [31:0] p);
    vld[id] = 1'b1;
    pix[id] = p;
    tick();
    vld[id] = 1'b0;
  endtask

  // Drives one full window; the result is due two cycles after the last tap.
  task automatic window(input int id, input int depth, input logic [31:0] p,
                        input logic [31:0] e, input int max_gap);
    for (int k = 0; k < depth; k++) begin
      if (k == depth - 1) sbq.push_back('{id, e, cyc + 2});
      tap(id, p);
      if (max_gap > 0 && k < depth - 1) repeat ($urandom_range(max_gap)) tick();
    end
  endtask

  task automatic load_w(input int id, input logic [31:0] w);
    wld[id] = 1'b1;
    win[id] = w;
    tick();
    wld[id] = 1'b0;
  endtask

  // Monitor: every result pulse must match the head of the scoreboard.
  always @(negedge clk) begin : monitor
    exp_t e;
    for (int id = 0; id < 3; id++) begin
      if (ov[id] === 1'b1) begin
        $display("dut%0d result %0d at cycle %0d", id, outv[id], cyc);
        if (sbq.size() == 0) begin
          chk($sformatf("unexpected_pulse_dut%0d", id), 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("pulse_dut_id", id, e.id);
          chk("result_value", outv[id], e.val);
          chk("result_cycle", cyc, e.cyc);
        end
      end
    end
    if (!rst) chk("depth1_busy", 32'(busy[2]), 32'd0);
  end

  initial begin
    logic [7:0]  kb;
    logic [21:0] neg90;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wld[i] = 1'b0; win[i] = '0; vld[i] = 1'b0; pix[i] = '0; clr[i] = 1'b0;
    end
    repeat (3) tick();
    chk("rst_output", 32'(a_out), 32'd0);
    chk("rst_out_valid", 32'(ov[0]), 32'd0);
    chk("rst_busy", 32'(busy[0]), 32'd0);
    chk("rst_weight", wo[0], 32'd0);
    chk("rst_valid_out", 32'(vo[0]), 32'd0);
    rst = 1'b0;
    tick();

    // Weights 1, pixels 2, contiguous window -> 72.
    load_w(0, 32'h01010101);
    chk("weight_load", wo[0], 32'h01010101);
    tap(0, 32'h02020202);
    chk("busy_after_first", 32'(busy[0]), 32'd1);
    chk("pixel_forward", pix_o[0], 32'h02020202);
    chk("valid_forward", 32'(vo[0]), 32'd1);
    for (int k = 1; k < 9; k++) begin
      if (k == 8) sbq.push_back('{0, 32'd72, cyc + 2});
      tap(0, 32'h02020202);
    end
    chk("busy_after_last", 32'(busy[0]), 32'd0);
    repeat (3) tick();
    chk("valid_forward_idle", 32'(vo[0]), 32'd0);
    chk("output_hold", 32'(a_out), 32'd72);

    // Gapped window, then two back-to-back windows.
    window(0, 9, 32'h01010101, 32'd36, 3);
    window(0, 9, 32'h01010101, 32'd36, 0);
    window(0, 9, 32'h03030303, 32'd108, 0);
    repeat (4) tick();

    // Clear together with tap 5: no result, previous output kept.
    for (int k = 0; k < 4; k++) tap(0, 32'h02020202);
    clr[0] = 1'b1;
    tap(0, 32'h02020202);
    clr[0] = 1'b0;
    repeat (4) tick();
    chk("clear_keeps_output", 32'(a_out), 32'd108);
    chk("clear_busy", 32'(busy[0]), 32'd0);
    window(0, 9, 32'h02020202, 32'd72, 0);
    repeat (4) tick();

    // Weight load in the same cycle as tap 1: 1*1*4 + 8*(2*1*4) = 68.
    wld[0] = 1'b1;
    win[0] = 32'h02020202;
    tap(0, 32'h01010101);
    wld[0] = 1'b0;
    chk("weight_new", wo[0], 32'h02020202);
    for (int k = 1; k < 9; k++) begin
      if (k == 8) sbq.push_back('{0, 32'd68, cyc + 2});
      tap(0, 32'h01010101);
    end
    repeat (4) tick();
    chk("output_68", 32'(a_out), 32'd68);

    // Reset mid-window.
    for (int k = 0; k < 3; k++) tap(0, 32'h01010101);
    rst = 1'b1;
    tap(0, 32'h01010101);
    rst = 1'b0;
    chk("midrst_output", 32'(a_out), 32'd0);
    chk("midrst_weight", wo[0], 32'd0);
    chk("midrst_busy", 32'(busy[0]), 32'd0);
    chk("midrst_valid_out", 32'(vo[0]), 32'd0);
    chk("midrst_pixel_out", pix_o[0], 32'd0);
    repeat (4) tick();

    // Signed: weights {-1,2,-3,4}, pixels -5 -> -90; then -128 x -128 -> 589824.
    neg90 = -22'sd90;
    load_w(1, 32'h04FD02FF);
    window(1, 9, 32'hFBFBFBFB, 32'(neg90), 0);
    repeat (4) tick();
    load_w(1, 32'h80808080);
    window(1, 9, 32'h80808080, 32'd589824, 0);
    repeat (4) tick();

    // Depth 1: one pulse per tap, weights 3, pixels k -> 12k.
    load_w(2, 32'h03030303);
    for (int k = 1; k <= 5; k++) begin
      kb = 8'(k);
      window(2, 1, {kb, kb, kb, kb}, 32'(12 * k), 0);
    end
    repeat (5) tick();

    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
